vga_fifo_sc: RTL

Single-clock, parametrised data FIFO for the VGA/LCD pixel path, sitting between the Wishbone master line-fetch logic and the pixel generator when both run from one clock. It is the successor to the dual-clock pointer/flag FIFO. It adds:
- on-chip data storage;
- an exact occupancy count and programmable almost-full/almost-empty thresholds;
- synchronous flush;
- sticky overflow and underflow error flags;
- a compile-time first-word-fall-through read mode.

---
 rtl/vga_fifo_sc.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/vga_fifo_sc.sv
// ---------------------------------------------------------------------------
// vga_fifo_sc
// Single-clock pixel-path data FIFO between the line-fetch master and the
// pixel generator. It has on-chip storage, an exact occupancy count,
// programmable almost-full/almost-empty thresholds, a synchronous flush and
// sticky overflow/underflow flags.
//
// Compile-time option:
//   VGA_FIFO_FWFT_EN  defined   : first-word-fall-through. q shows the head
//                                 word whenever empty=0, and rreq
//                                 acknowledges that word.
//                     undefined : standard mode. q is loaded only on an
//                                 accepted read.
//
// Ports:
//   clk        rising-edge clock
//   nrst       synchronous reset, active low
//   sclr       synchronous flush, active high (nrst has priority)
//   wreq, d    write request and data
//   rreq, q    read request and data
//   afull_lvl  almost-full threshold  (afull  = level >= afull_lvl)
//   aempty_lvl almost-empty threshold (aempty = level <= aempty_lvl)
//   level      occupancy 0..DEPTH
//   empty/full/afull/aempty  registered status flags, consistent with level
//   ovf/udf    sticky write-while-full / read-while-empty
// ---------------------------------------------------------------------------
module vga_fifo_sc #(
    parameter int AWIDTH = 7,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              sclr,
    input  logic              wreq,
    input  logic [DWIDTH-1:0] d,
    input  logic              rreq,
    output logic [DWIDTH-1:0] q,
    input  logic [AWIDTH:0]   afull_lvl,
    input  logic [AWIDTH:0]   aempty_lvl,
    output logic [AWIDTH:0]   level,
    output logic              empty,
    output logic              full,
    output logic              afull,
    output logic              aempty,
    output logic              ovf,
    output logic              udf
);

    localparam int              DEPTH    = 1 << AWIDTH;
    localparam logic [AWIDTH:0] FULL_LVL = (AWIDTH+1)'(DEPTH);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic [AWIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AWIDTH:0]   level_q, level_d;
    logic [DWIDTH-1:0] q_q, q_d;
    logic              empty_q, empty_d, full_q, full_d;
    logic              afull_q, afull_d, aempty_q, aempty_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              wr_acc, rd_acc;

    // Acceptance is judged against this cycle's registered flags, so a
    // simultaneous read cannot make room for a write when full (and vice
    // versa when empty).
    assign wr_acc = wreq & ~full_q;
    assign rd_acc = rreq & ~empty_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        q_d     = q_q;
        if (sclr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + 1'b1;
            if (rd_acc) rptr_d = rptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            if (wreq & full_q)  ovf_d = 1'b1;
            if (rreq & empty_q) udf_d = 1'b1;
`ifdef VGA_FIFO_FWFT_EN
            // The head word is kept in q. A write into an empty FIFO becomes
            // the head directly. On a read, the next head is the following
            // slot, or the word being written if that slot is not yet in
            // memory. q holds once the FIFO runs dry.
            if (wr_acc && level_q == '0)
                q_d = d;
            else if (rd_acc && level_d != '0)
                q_d = (level_q == 1) ? d : mem_q[rptr_q + 1'b1];
`else
            if (rd_acc) q_d = mem_q[rptr_q];
`endif
        end
        empty_d  = (level_d == '0);
        full_d   = (level_d == FULL_LVL);
        afull_d  = (level_d >= afull_lvl);
        aempty_d = (level_d <= aempty_lvl);
    end

    // Storage has no reset. A flush leaves its contents in place.
    always_ff @(posedge clk) begin
        if (nrst && !sclr && wr_acc) mem_q[wptr_q] <= d;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            q_q      <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            q_q      <= q_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign q      = q_q;
    assign level  = level_q;
    assign empty  = empty_q;
    assign full   = full_q;
    assign afull  = afull_q;
    assign aempty = aempty_q;
    assign ovf    = ovf_q;
    assign udf    = udf_q;

endmodule
